// File: rtl/ahb_bridge_arbiter_if.sv
// rtl/ahb_bridge_arbiter_if.sv - request/grant bundle between AHB masters and the bridge arbiter
interface ahb_bridge_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] Hbusreq;
  logic [NUM_MASTERS-1:0] Hlock;
  logic [1:0]             Htrans;
  logic                   Hreadyout;
  logic [NUM_MASTERS-1:0] Hgrant;
  logic [IDX_W-1:0]       Hmaster;
  logic [IDX_W-1:0]       Hmaster_data;
  logic                   Hmastlock;

  // Requesting side: masters raise requests and see the muxed transfer state
  modport master (
    output Hbusreq, Hlock, Htrans, Hreadyout,
    input  Hgrant, Hmaster, Hmaster_data, Hmastlock
  );

  // Arbiter side: consumes requests, drives grant and owner indices
  modport slave (
    input  Hbusreq, Hlock, Htrans, Hreadyout,
    output Hgrant, Hmaster, Hmaster_data, Hmastlock
  );
endinterface

// File: rtl/ahb_bridge_arbiter.sv
// rtl/ahb_bridge_arbiter.sv - round-robin AHB arbiter sharing the AHB-to-APB bridge port
module ahb_bridge_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_BEATS   = 16
) (
  input logic               Hclk,
  input logic               Hresetn,
  ahb_bridge_arbiter_if.slave bus
);
  localparam int                     IDX_W     = $clog2(NUM_MASTERS);
  localparam logic [7:0]             MAX_B     = 8'(MAX_BEATS);
  localparam logic [NUM_MASTERS-1:0] GRANT_M0  = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [1:0]             HT_IDLE   = 2'b00;
  localparam logic [1:0]             HT_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_OWN    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       master_q;
  logic [IDX_W-1:0]       master_data_q;
  logic                   mastlock_q;
  logic [IDX_W-1:0]       rr_ptr;
  logic [7:0]             beat_cnt;

  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic                   pick_lock;
  logic                   do_grant;
  logic                   park_zero;

  logic own_req;
  logic own_lock;
  logic others_req;
  logic any_req;
  logic boundary;
  logic count_beat;
  logic cap_hit;

  // Owner-relative views use the one-hot grant as a mask, so no variable indexing is needed
  assign own_req    = |(bus.Hbusreq & grant_q);
  assign own_lock   = |(bus.Hlock & grant_q);
  assign others_req = |(bus.Hbusreq & ~grant_q);
  assign any_req    = |bus.Hbusreq;
  assign boundary   = (bus.Htrans == HT_IDLE) || (bus.Htrans == HT_NONSEQ);
  assign count_beat = bus.Htrans[1];
  assign cap_hit    = (beat_cnt >= MAX_B);
  assign pick_lock  = |(bus.Hlock & pick_oh);

  // Round-robin search starting one past the last winner; the last winner is visited last
  always_comb begin
    int                     j;
    logic [NUM_MASTERS-1:0] cand;
    logic                   found;
    j        = 0;
    cand     = '0;
    found    = 1'b0;
    pick_idx = rr_ptr;
    pick_oh  = grant_q;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      cand = GRANT_M0 << j;
      if (!found && |(bus.Hbusreq & cand)) begin
        found    = 1'b1;
        pick_idx = IDX_W'(j);
        pick_oh  = cand;
      end
    end
  end

  // Arbitration decision: when to hand over, park or lock, evaluated for the coming ready edge
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    park_zero = 1'b0;
    case (state)
      ST_PARK: begin
        if (any_req) begin
          do_grant  = 1'b1;
          state_nxt = pick_lock ? ST_LOCKED : ST_OWN;
        end
      end
      ST_OWN: begin
        if (boundary && !own_req) begin
          if (others_req) begin
            do_grant  = 1'b1;
            state_nxt = pick_lock ? ST_LOCKED : ST_OWN;
          end else begin
            state_nxt = ST_PARK;
          end
        end else if (own_lock) begin
          state_nxt = ST_LOCKED;
        end else if (boundary && cap_hit && others_req) begin
          do_grant  = 1'b1;
          state_nxt = pick_lock ? ST_LOCKED : ST_OWN;
        end
      end
      ST_LOCKED: begin
        if (boundary && !own_lock) begin
          state_nxt = ST_OWN;
          if (!own_req) begin
            if (others_req) begin
              do_grant  = 1'b1;
              state_nxt = pick_lock ? ST_LOCKED : ST_OWN;
            end else begin
              state_nxt = ST_PARK;
            end
          end else if (cap_hit && others_req) begin
            do_grant  = 1'b1;
            state_nxt = pick_lock ? ST_LOCKED : ST_OWN;
          end
        end
      end
      default: begin
        state_nxt = ST_PARK;
        park_zero = 1'b1;
      end
    endcase
  end

  // Registered FSM and outputs; nothing moves while the bridge inserts wait states
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state         <= ST_PARK;
      grant_q       <= GRANT_M0;
      master_q      <= '0;
      master_data_q <= '0;
      mastlock_q    <= 1'b0;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
    end else if (bus.Hreadyout) begin
      state         <= state_nxt;
      master_data_q <= master_q;
      mastlock_q    <= (state_nxt == ST_LOCKED);
      if (park_zero) begin
        grant_q  <= GRANT_M0;
        master_q <= '0;
        rr_ptr   <= '0;
        beat_cnt <= '0;
      end else if (do_grant) begin
        grant_q  <= pick_oh;
        master_q <= pick_idx;
        rr_ptr   <= pick_idx;
        beat_cnt <= '0;
      end else if (count_beat && !cap_hit) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  assign bus.Hgrant       = grant_q;
  assign bus.Hmaster      = master_q;
  assign bus.Hmaster_data = master_data_q;
  assign bus.Hmastlock    = mastlock_q;
endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// tb/tb_ahb_bridge_arbiter.sv - directed self-checking bench for ahb_bridge_arbiter
module tb_ahb_bridge_arbiter;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic Hclk = 1'b0;
  logic Hresetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Free-running 100 MHz-style clock
  always #5 Hclk = ~Hclk;

  ahb_bridge_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_bridge_arbiter #(
    .NUM_MASTERS(4),
    .MAX_BEATS  (4)
  ) dut (
    .Hclk   (Hclk),
    .Hresetn(Hresetn),
    .bus    (bus)
  );

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] tr, input logic rdy);
    bus.Hbusreq   = req;
    bus.Hlock     = lck;
    bus.Htrans    = tr;
    bus.Hreadyout = rdy;
  endtask

  task automatic do_reset();
    Hresetn = 1'b0;
    drive(4'b0000, 4'b0000, T_IDLE, 1'b1);
    step();
    step();
    Hresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.Hgrant !== 4'b0001) begin n_fail++; $display("FAIL reset_grant: got %b expected 0001", bus.Hgrant); end
    n_checks++; if (bus.Hmaster !== 2'd0) begin n_fail++; $display("FAIL reset_master: got %0d expected 0", bus.Hmaster); end
    n_checks++; if (bus.Hmaster_data !== 2'd0) begin n_fail++; $display("FAIL reset_master_data: got %0d expected 0", bus.Hmaster_data); end
    n_checks++; if (bus.Hmastlock !== 1'b0) begin n_fail++; $display("FAIL reset_mastlock: got %b expected 0", bus.Hmastlock); end
    // Master 2 takes a locked tenure and starts a burst
    drive(4'b0100, 4'b0100, T_IDLE, 1'b1);
    step();
    n_checks++; if (bus.Hgrant !== 4'b0100 || bus.Hmastlock !== 1'b1) begin n_fail++; $display("FAIL reset_pregrant: got grant %b lock %b expected 0100 1", bus.Hgrant, bus.Hmastlock); end
    drive(4'b0100, 4'b0100, T_NONSEQ, 1'b1);
    step();
    drive(4'b0100, 4'b0100, T_SEQ, 1'b1);
    step();
    #2;
    Hresetn = 1'b0;
    #1;
    n_checks++; if (bus.Hgrant !== 4'b0001) begin n_fail++; $display("FAIL reset_async_grant: got %b expected 0001", bus.Hgrant); end
    n_checks++; if (bus.Hmaster !== 2'd0) begin n_fail++; $display("FAIL reset_async_master: got %0d expected 0", bus.Hmaster); end
    n_checks++; if (bus.Hmastlock !== 1'b0) begin n_fail++; $display("FAIL reset_async_mastlock: got %b expected 0", bus.Hmastlock); end
    n_checks++; if (bus.Hmaster_data !== 2'd0) begin n_fail++; $display("FAIL reset_async_master_data: got %0d expected 0", bus.Hmaster_data); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_seq [4];
    logic [1:0] cur;
    logic [3:0] req;
    exp_seq = '{2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    drive(4'b1111, 4'b0000, T_IDLE, 1'b1);
    step();
    n_checks++; if (bus.Hmaster !== 2'd1) begin n_fail++; $display("FAIL rotation_first: got %0d expected 1", bus.Hmaster); end
    cur = 2'd1;
    for (int k = 0; k < 4; k++) begin
      drive(4'b1111, 4'b0000, T_NONSEQ, 1'b1);
      step();
      n_checks++; if (bus.Hmaster !== cur) begin n_fail++; $display("FAIL rotation_hold[%0d]: got %0d expected %0d", k, bus.Hmaster, cur); end
      req = 4'b1111 & ~(4'b0001 << cur);
      drive(req, 4'b0000, T_IDLE, 1'b1);
      step();
      n_checks++; if (bus.Hmaster !== exp_seq[k]) begin n_fail++; $display("FAIL rotation_next[%0d]: got %0d expected %0d", k, bus.Hmaster, exp_seq[k]); end
      n_checks++; if (bus.Hgrant !== (4'b0001 << exp_seq[k])) begin n_fail++; $display("FAIL rotation_grant[%0d]: got %b expected %b", k, bus.Hgrant, 4'b0001 << exp_seq[k]); end
      n_checks++; if (bus.Hmaster_data !== cur) begin n_fail++; $display("FAIL rotation_data[%0d]: got %0d expected %0d", k, bus.Hmaster_data, cur); end
      cur = exp_seq[k];
    end
  endtask

  task automatic test_burst_protect();
    do_reset();
    drive(4'b0100, 4'b0000, T_IDLE, 1'b1);
    step();
    n_checks++; if (bus.Hmaster !== 2'd2) begin n_fail++; $display("FAIL burst_grant: got %0d expected 2", bus.Hmaster); end
    drive(4'b0100, 4'b0000, T_NONSEQ, 1'b1);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1011, 4'b0000, (i == 3) ? T_BUSY : T_SEQ, 1'b1);
      step();
      n_checks++; if (bus.Hgrant !== 4'b0100) begin n_fail++; $display("FAIL burst_hold[%0d]: got %b expected 0100", i, bus.Hgrant); end
    end
    drive(4'b1011, 4'b0000, T_IDLE, 1'b1);
    step();
    n_checks++; if (bus.Hmaster !== 2'd3 || bus.Hgrant !== 4'b1000) begin n_fail++; $display("FAIL burst_handoff: got %0d/%b expected 3/1000", bus.Hmaster, bus.Hgrant); end
  endtask

  task automatic test_tenure_cap();
    do_reset();
    drive(4'b0011, 4'b0000, T_IDLE, 1'b1);
    step();
    n_checks++; if (bus.Hmaster !== 2'd1) begin n_fail++; $display("FAIL cap_grant: got %0d expected 1", bus.Hmaster); end
    for (int i = 0; i < 4; i++) begin
      drive(4'b0011, 4'b0000, T_NONSEQ, 1'b1);
      step();
      n_checks++; if (bus.Hmaster !== 2'd1) begin n_fail++; $display("FAIL cap_hold[%0d]: got %0d expected 1", i, bus.Hmaster); end
    end
    step();
    n_checks++; if (bus.Hmaster !== 2'd0 || bus.Hgrant !== 4'b0001) begin n_fail++; $display("FAIL cap_preempt: got %0d/%b expected 0/0001", bus.Hmaster, bus.Hgrant); end
    for (int i = 0; i < 6; i++) begin
      drive(4'b0001, 4'b0000, T_NONSEQ, 1'b1);
      step();
    end
    n_checks++; if (bus.Hmaster !== 2'd0) begin n_fail++; $display("FAIL cap_alone: got %0d expected 0", bus.Hmaster); end
  endtask

  task automatic test_lock();
    do_reset();
    drive(4'b1000, 4'b1000, T_IDLE, 1'b1);
    step();
    n_checks++; if (bus.Hgrant !== 4'b1000 || bus.Hmastlock !== 1'b1) begin n_fail++; $display("FAIL lock_grant: got %b lock %b expected 1000 1", bus.Hgrant, bus.Hmastlock); end
    for (int i = 0; i < 20; i++) begin
      drive(4'b1111, 4'b1000, T_NONSEQ, 1'b1);
      step();
      n_checks++; if (bus.Hgrant !== 4'b1000 || bus.Hmastlock !== 1'b1) begin n_fail++; $display("FAIL lock_hold[%0d]: got %b lock %b expected 1000 1", i, bus.Hgrant, bus.Hmastlock); end
    end
    drive(4'b1111, 4'b0000, T_SEQ, 1'b1);
    step();
    n_checks++; if (bus.Hgrant !== 4'b1000 || bus.Hmastlock !== 1'b1) begin n_fail++; $display("FAIL lock_seq_after_release: got %b lock %b expected 1000 1", bus.Hgrant, bus.Hmastlock); end
    drive(4'b1111, 4'b0000, T_NONSEQ, 1'b1);
    step();
    n_checks++; if (bus.Hgrant !== 4'b0001 || bus.Hmaster !== 2'd0 || bus.Hmastlock !== 1'b0) begin n_fail++; $display("FAIL lock_handoff: got %b/%0d lock %b expected 0001/0 0", bus.Hgrant, bus.Hmaster, bus.Hmastlock); end
    drive(4'b1111, 4'b0001, T_SEQ, 1'b1);
    step();
    n_checks++; if (bus.Hgrant !== 4'b0001 || bus.Hmastlock !== 1'b1) begin n_fail++; $display("FAIL lock_rise_midburst: got %b lock %b expected 0001 1", bus.Hgrant, bus.Hmastlock); end
  endtask

  task automatic test_wait_states();
    do_reset();
    drive(4'b0010, 4'b0000, T_IDLE, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, 4'b0000, T_NONSEQ, 1'b1);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      drive(4'b0110, 4'b0000, T_NONSEQ, 1'b0);
      step();
      n_checks++; if (bus.Hmaster !== 2'd1) begin n_fail++; $display("FAIL wait_cnt_freeze[%0d]: got %0d expected 1", i, bus.Hmaster); end
    end
    drive(4'b0110, 4'b0000, T_NONSEQ, 1'b1);
    step();
    n_checks++; if (bus.Hmaster !== 2'd1) begin n_fail++; $display("FAIL wait_cnt_not_counted: got %0d expected 1", bus.Hmaster); end
    step();
    n_checks++; if (bus.Hmaster !== 2'd2) begin n_fail++; $display("FAIL wait_cap_after: got %0d expected 2", bus.Hmaster); end
    for (int i = 0; i < 5; i++) begin
      drive(4'b0010, 4'b0000, T_IDLE, 1'b0);
      step();
      n_checks++; if (bus.Hgrant !== 4'b0100 || bus.Hmaster !== 2'd2 || bus.Hmaster_data !== 2'd1) begin n_fail++; $display("FAIL wait_freeze[%0d]: got %b/%0d/%0d expected 0100/2/1", i, bus.Hgrant, bus.Hmaster, bus.Hmaster_data); end
    end
    drive(4'b0010, 4'b0000, T_IDLE, 1'b1);
    step();
    n_checks++; if (bus.Hmaster !== 2'd1 || bus.Hgrant !== 4'b0010 || bus.Hmaster_data !== 2'd2) begin n_fail++; $display("FAIL wait_handoff: got %0d/%b/%0d expected 1/0010/2", bus.Hmaster, bus.Hgrant, bus.Hmaster_data); end
  endtask

  // Scenario sequence
  initial begin
    Hresetn = 1'b0;
    drive(4'b0000, 4'b0000, T_IDLE, 1'b1);
    test_reset();
    test_rotation();
    test_burst_protect();
    test_tenure_cap();
    test_lock();
    test_wait_states();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
